// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ERR
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   din,
    output entry_t                   dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem[wr_ptr] <= din;
    end

    // Head reads zero when empty so stale storage never leaks to decode.
    always_comb begin
        dout = '0;
        if (!empty) dout = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage ROM sequencer with prefetch FIFO and redirect handling.
// Optional perf counters are enabled by defining FETCH_PERF_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned         ADDR_WIDTH  = 32,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter int unsigned         FIFO_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic                   misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_e             state;
    logic [ADDR_WIDTH-1:0]    fetch_pc;
    logic                     redirect_ok;
    logic                     redirect_bad;
    logic                     flush;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    entry_t                   fifo_din;
    entry_t                   fifo_dout;

    assign redirect_ok  = redirect_valid && (state != ERR) && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (state != ERR) && (redirect_pc[1:0] != 2'b00);
    assign flush        = redirect_valid && (state != ERR);
    assign pop          = out_ready && !fifo_empty && !redirect_valid;
    assign push         = (state == RUN) && fetch_en && !redirect_valid && (!fifo_full || pop);

    assign fifo_din  = '{pc: fetch_pc, instr: imem_instr};
    assign imem_addr = fetch_pc;
    assign out_valid = (fifo_count != '0);
    assign out_pc    = fifo_dout.pc;
    assign out_instr = fifo_dout.instr;

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A redirect in IDLE retargets fetch but does not start it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_bad) begin
                        state        <= ERR;
                        misalign_err <= 1'b1;
                    end else if (redirect_ok) begin
                        fetch_pc <= redirect_pc;
                    end else if (fetch_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (redirect_bad) begin
                        state        <= ERR;
                        misalign_err <= 1'b1;
                    end else begin
                        if (redirect_ok)
                            fetch_pc <= redirect_pc;
                        else if (push)
                            fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
                        if (!fetch_en) state <= IDLE;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic stall_cycle;

    assign stall_cycle = (state == RUN) && fetch_en && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && perf_fetched != '1)       perf_fetched <= perf_fetched + 1'b1;
            if (stall_cycle && perf_stall != '1)  perf_stall   <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus, decoupled delivery monitor.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    assign imem_instr = rom_word(imem_addr);

    fetch_ctrl #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .FIFO_DEPTH  (2),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, instr: rom_word(pc)});
    endfunction

    // Delivery monitor: every accepted head must match the next queued entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL deliver: unexpected entry pc=%h instr=%h", out_pc, out_instr);
            end else begin
                check("deliver", {out_pc, out_instr}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state, first-fetch latency, streaming throughput
        fetch_en = 1'b1; out_ready = 1'b1;
        step(2);
        check("rst_valid",    64'(out_valid),    64'(0));
        check("rst_addr",     64'(imem_addr),    64'(0));
        check("rst_pc",       64'(out_pc),       64'(0));
        check("rst_instr",    64'(out_instr),    64'(0));
        check("rst_misalign", 64'(misalign_err), 64'(0));
        rst = 1'b0;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        step(1);
        check("lat_valid0", 64'(out_valid), 64'(0));
        step(1);
        check("lat_valid1", 64'(out_valid), 64'(1));
        check("lat_pc0",    64'(out_pc),    64'(32'h0));
        step(1);
        check("tput_pc1",   64'(out_pc),    64'(32'h4));
        step(1);
        check("tput_pc2",   64'(out_pc),    64'(32'h8));
        step(1);
        fetch_en = 1'b0;
        step(4);
        check("drain_stream", 64'(exp_q.size()), 64'(0));

        // Stall: FIFO fills to two, fetch_pc holds
        rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);
        check("stall_addr_a", 64'(imem_addr), 64'(32'h8));
        step(3);
        check("stall_addr_b", 64'(imem_addr), 64'(32'h8));
        check("stall_valid",  64'(out_valid), 64'(1));
        check("stall_head",   64'(out_pc),    64'(32'h0));
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        out_ready = 1'b1;
        step(2);
        fetch_en = 1'b0;
        step(4);
        check("drain_stall", 64'(exp_q.size()), 64'(0));

        // Redirect while full flushes pre-redirect entries
        rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step(1);
        redirect_valid = 1'b0; out_ready = 1'b1;
        check("redir_bubble", 64'(out_valid), 64'(0));
        check("redir_addr",   64'(imem_addr), 64'(32'h40));
        expect_pc(32'h40); expect_pc(32'h44);
        step(1);
        check("redir_head",   64'(out_pc),    64'(32'h40));
        step(1);
        fetch_en = 1'b0;
        step(4);
        check("drain_redir", 64'(exp_q.size()), 64'(0));

        // Redirect in IDLE, then PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        check("idle_redir_addr", 64'(imem_addr), 64'(32'hFFFF_FFFC));
        step(1);
        check("idle_stays",      64'(imem_addr), 64'(32'hFFFF_FFFC));
        expect_pc(32'hFFFF_FFFC); expect_pc(32'h0000_0000);
        fetch_en = 1'b1;
        step(3);
        fetch_en = 1'b0;
        step(4);
        check("drain_wrap", 64'(exp_q.size()), 64'(0));
        check("wrap_addr",  64'(imem_addr), 64'(32'h4));

        // Back-to-back redirects: last wins
        fetch_en = 1'b1;
        step(1);
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step(1);
        redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        check("b2b_addr",  64'(imem_addr), 64'(32'h100));
        check("b2b_valid", 64'(out_valid), 64'(0));
        expect_pc(32'h100); expect_pc(32'h104);
        step(2);
        fetch_en = 1'b0;
        step(4);
        check("drain_b2b", 64'(exp_q.size()), 64'(0));

        // Misaligned redirect: sticky error, frozen fetch, async reset recovery
        out_ready = 1'b0; fetch_en = 1'b1;
        step(3);
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        step(1);
        redirect_valid = 1'b0;
        check("mis_err",   64'(misalign_err), 64'(1));
        check("mis_valid", 64'(out_valid),    64'(0));
        check("mis_addr",  64'(imem_addr),    64'(32'h110));
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        step(3);
        check("mis_sticky", 64'(misalign_err), 64'(1));
        check("mis_valid2", 64'(out_valid),    64'(0));
        check("mis_frozen", 64'(imem_addr),    64'(32'h110));
        #2;
        rst = 1'b1;
        #1;
        check("async_err",   64'(misalign_err), 64'(0));
        check("async_addr",  64'(imem_addr),    64'(0));
        check("async_valid", 64'(out_valid),    64'(0));
        step(1);
        rst = 1'b0;
        expect_pc(32'h0); expect_pc(32'h4);
        step(3);
        fetch_en = 1'b0;
        step(4);
        check("drain_recover", 64'(exp_q.size()), 64'(0));

`ifdef FETCH_PERF_EN
        // Perf counters over a held stall from reset
        rst = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
        step(1);
        check("perf_rst_f", 64'(perf_fetched), 64'(0));
        check("perf_rst_s", 64'(perf_stall),   64'(0));
        rst = 1'b0;
        step(11);
        check("perf_fetched", 64'(perf_fetched), 64'(2));
        check("perf_stall",   64'(perf_stall),   64'(8));
        expect_pc(32'h0); expect_pc(32'h4);
        fetch_en = 1'b0; out_ready = 1'b1;
        step(4);
        check("drain_perf", 64'(exp_q.size()), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
